// File: rtl/eth_tx_interface.sv
// eth_tx_interface
//   Transmit-side 64b/66b block builder. Takes a byte stream from the MAC
//   framer and emits 66-bit blocks to the scrambler/gearbox as two 32-bit
//   words per block. The 2-bit sync header is presented with the first word.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_eths_slave_data       input beat, byte 0 (first on wire) in [7:0]
//   i_eths_slave_keep       valid bytes minus 1 on the last beat
//   i_eths_slave_valid      beat valid
//   i_eths_slave_last       final beat of frame
//   i_eths_slave_abort      frame abort, sampled with valid
//   o_eths_slave_ready      beat accepted when valid && ready
//   o_data                  PCS word, first wire byte in [31:24]
//   o_data_valid            o_data holds a new word
//   o_header                sync header (01 data, 10 control)
//   o_header_valid          high on the first word of each block
//   i_tx_ready              gearbox accepts a word this cycle
//   o_underrun              one-cycle pulse when a frame is truncated
`timescale 1ns/1ps
module eth_tx_interface #(
  parameter int unsigned DATAPATH_WIDTH = 32,
  parameter int unsigned IPG_BLOCKS     = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DATAPATH_WIDTH-1:0] i_eths_slave_data,
  input  logic [1:0]                i_eths_slave_keep,
  input  logic                      i_eths_slave_valid,
  input  logic                      i_eths_slave_last,
  input  logic                      i_eths_slave_abort,
  output logic                      o_eths_slave_ready,
  output logic [DATAPATH_WIDTH-1:0] o_data,
  output logic                      o_data_valid,
  output logic [1:0]                o_header,
  output logic                      o_header_valid,
  input  logic                      i_tx_ready,
  output logic                      o_underrun
);

  if (DATAPATH_WIDTH != 32) begin : g_bad_width
    $error("eth_tx_interface: only DATAPATH_WIDTH=32 is supported");
  end
  if (IPG_BLOCKS < 1 || IPG_BLOCKS > 15) begin : g_bad_ipg
    $error("eth_tx_interface: IPG_BLOCKS must be in 1..15");
  end

  localparam logic [1:0]  HDR_DATA  = 2'b01;
  localparam logic [1:0]  HDR_CTRL  = 2'b10;
  localparam logic [63:0] BLK_IDLE  = 64'h78000000_00000000;
  localparam logic [63:0] BLK_START = 64'h1E555555_555555D5;
  localparam logic [63:0] BLK_ERROR = 64'h783C78F1_E3C78F1E;
  localparam logic [3:0]  IPG_LOAD  = 4'(IPG_BLOCKS - 1);

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  keep;
    logic        last;
    logic        abort;
  } beat_t;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TERM0, S_IPG} state_t;

  state_t      state_q, state_n;
  logic [3:0]  ipg_q, ipg_n;
  logic        half_q, run_q, drop_q, drop_n;
  beat_t       buf0_q, buf1_q, buf0_n, buf1_n, beat_in;
  logic [1:0]  cnt_q, cnt_n, cnt_after, pop;
  logic [31:0] w1_q;
  logic [63:0] blk, term_blk, b64;
  logic [1:0]  blk_hdr;
  logic        flush, underrun, use_term, has_last, abort_any;
  logic        drop_now, accept, push;
  logic [2:0]  term_k;

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [7:0] term_type(input logic [2:0] k);
    case (k)
      3'd0:    return 8'hE1;
      3'd1:    return 8'h99;
      3'd2:    return 8'h55;
      3'd3:    return 8'h2D;
      3'd4:    return 8'h33;
      3'd5:    return 8'h4B;
      3'd6:    return 8'h87;
      default: return 8'hFF;
    endcase
  endfunction

  assign b64       = {swap32(buf0_q.data), swap32(buf1_q.data)};
  assign has_last  = (cnt_q != 2'd0 && buf0_q.last) || (cnt_q == 2'd2 && buf1_q.last);
  assign abort_any = (cnt_q != 2'd0 && buf0_q.abort) || (cnt_q == 2'd2 && buf1_q.abort);

  // Block decision: only at the start of a block (half 0) with the gearbox ready.
  always_comb begin : decide_proc
    state_n  = state_q;
    ipg_n    = ipg_q;
    blk_hdr  = HDR_CTRL;
    blk      = BLK_IDLE;
    pop      = 2'd0;
    flush    = 1'b0;
    underrun = 1'b0;
    use_term = 1'b0;
    term_k   = 3'd0;
    if (i_tx_ready && !half_q) begin
      case (state_q)
        S_IDLE: begin
          if (cnt_q != 2'd0) begin
            blk     = BLK_START;
            state_n = S_DATA;
          end
        end
        S_DATA: begin
          if (abort_any) begin
            blk     = BLK_ERROR;
            flush   = 1'b1;
            state_n = S_IPG;
            ipg_n   = IPG_LOAD;
          end else if (cnt_q != 2'd0 && buf0_q.last) begin
            use_term = 1'b1;
            term_k   = 3'(buf0_q.keep) + 3'd1;
            pop      = 2'd1;
            state_n  = S_IPG;
            ipg_n    = IPG_LOAD;
          end else if (cnt_q == 2'd2) begin
            pop = 2'd2;
            if (buf1_q.last && buf1_q.keep != 2'd3) begin
              use_term = 1'b1;
              term_k   = 3'd5 + 3'(buf1_q.keep);
              state_n  = S_IPG;
              ipg_n    = IPG_LOAD;
            end else begin
              // A full 8-byte tail still needs a TERM_0 block after it.
              blk_hdr = HDR_DATA;
              blk     = b64;
              state_n = buf1_q.last ? S_TERM0 : S_DATA;
            end
          end else begin
            blk      = BLK_ERROR;
            flush    = 1'b1;
            underrun = 1'b1;
            state_n  = S_IPG;
            ipg_n    = IPG_LOAD;
          end
        end
        S_TERM0: begin
          use_term = 1'b1;
          state_n  = S_IPG;
          ipg_n    = IPG_LOAD;
        end
        default: begin
          if (ipg_q == 4'd0) state_n = S_IDLE;
          else               ipg_n   = ipg_q - 4'd1;
        end
      endcase
    end
    term_blk         = '0;
    term_blk[63:56]  = term_type(term_k);
    for (int unsigned i = 0; i < 7; i++) begin
      if (i < 32'(term_k)) term_blk[55-8*i -: 8] = b64[63-8*i -: 8];
    end
    if (use_term) blk = term_blk;
  end

  // The buffer only ever holds one frame, so a last beat is always at its tail.
  // When an error hits before the frame's last beat has arrived, the rest of
  // the frame is swallowed on input (drop) rather than buffered.
  always_comb begin : buffer_proc
    cnt_after          = flush ? 2'd0 : cnt_q - pop;
    drop_now           = drop_q || (flush && !has_last);
    o_eths_slave_ready = run_q && (drop_now ||
                         (cnt_after != 2'd2 && !(cnt_after != 2'd0 && has_last)));
    accept             = i_eths_slave_valid && o_eths_slave_ready;
    push               = accept && !drop_now;
    drop_n             = drop_now && !(accept && i_eths_slave_last);
    beat_in            = '{data: i_eths_slave_data, keep: i_eths_slave_keep,
                           last: i_eths_slave_last, abort: i_eths_slave_abort};
    buf0_n             = (pop == 2'd1) ? buf1_q : buf0_q;
    buf1_n             = buf1_q;
    if (push) begin
      if (cnt_after == 2'd0) buf0_n = beat_in;
      else                   buf1_n = beat_in;
    end
    cnt_n = cnt_after + {1'b0, push};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin : state_reg
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ipg_q   <= '0;
    end else begin
      state_q <= state_n;
      ipg_q   <= ipg_n;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin : data_reg
    if (!i_rst_n) begin
      run_q          <= 1'b0;
      half_q         <= 1'b0;
      drop_q         <= 1'b0;
      cnt_q          <= '0;
      buf0_q         <= '0;
      buf1_q         <= '0;
      w1_q           <= '0;
      o_data         <= '0;
      o_data_valid   <= 1'b0;
      o_header       <= HDR_CTRL;
      o_header_valid <= 1'b0;
      o_underrun     <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      drop_q     <= drop_n;
      cnt_q      <= cnt_n;
      buf0_q     <= buf0_n;
      buf1_q     <= buf1_n;
      o_underrun <= underrun;
      if (i_tx_ready) begin
        o_data_valid <= 1'b1;
        half_q       <= ~half_q;
        if (!half_q) begin
          o_data         <= blk[63:32];
          w1_q           <= blk[31:0];
          o_header       <= blk_hdr;
          o_header_valid <= 1'b1;
        end else begin
          o_data         <= w1_q;
          o_header_valid <= 1'b0;
        end
      end else begin
        o_data_valid   <= 1'b0;
        o_header_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_interface.sv
// tb_eth_tx_interface
//   Directed bench for eth_tx_interface: reset values, idle stream, frames
//   of several tail lengths, underrun, abort and a gearbox slip cycle.
`timescale 1ns/1ps
module tb_eth_tx_interface;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_eths_slave_data = '0;
  logic [1:0]  i_eths_slave_keep = '0;
  logic        i_eths_slave_valid = 1'b0;
  logic        i_eths_slave_last = 1'b0;
  logic        i_eths_slave_abort = 1'b0;
  logic        o_eths_slave_ready;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic [1:0]  o_header;
  logic        o_header_valid;
  logic        i_tx_ready = 1'b1;
  logic        o_underrun;

  always #5 i_clk = ~i_clk;

  eth_tx_interface #(.DATAPATH_WIDTH(32), .IPG_BLOCKS(1)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_eths_slave_data  (i_eths_slave_data),
    .i_eths_slave_keep  (i_eths_slave_keep),
    .i_eths_slave_valid (i_eths_slave_valid),
    .i_eths_slave_last  (i_eths_slave_last),
    .i_eths_slave_abort (i_eths_slave_abort),
    .o_eths_slave_ready (o_eths_slave_ready),
    .o_data             (o_data),
    .o_data_valid       (o_data_valid),
    .o_header           (o_header),
    .o_header_valid     (o_header_valid),
    .i_tx_ready         (i_tx_ready),
    .o_underrun         (o_underrun)
  );

  typedef struct packed {
    logic [1:0]  hdr;
    logic [31:0] w0;
    logic [31:0] w1;
  } blk_t;

  localparam blk_t B_IDLE  = {2'b10, 32'h78000000, 32'h00000000};
  localparam blk_t B_START = {2'b10, 32'h1E555555, 32'h555555D5};
  localparam blk_t B_ERROR = {2'b10, 32'h783C78F1, 32'hE3C78F1E};

  logic [34:0] words[$];
  blk_t        blocks[$];
  blk_t        exp_q[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned und_cnt = 0;
  int unsigned misalign = 0;
  logic        cap_en = 1'b0;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge i_clk) begin
    if (cap_en) begin
      if (o_data_valid) words.push_back({o_header_valid, o_header, o_data});
      if (o_underrun) und_cnt++;
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [1:0] k,
                           input logic l, input logic a);
    int unsigned n;
    n = 0;
    i_eths_slave_data  = d;
    i_eths_slave_keep  = k;
    i_eths_slave_last  = l;
    i_eths_slave_abort = a;
    i_eths_slave_valid = 1'b1;
    #1;
    while (!o_eths_slave_ready && n < 200) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    check("ready_wait", 66'(n < 200), 66'(1));
    @(negedge i_clk);
    i_eths_slave_valid = 1'b0;
    i_eths_slave_last  = 1'b0;
    i_eths_slave_abort = 1'b0;
  endtask

  task automatic build_blocks();
    blk_t cur;
    logic have_w0, started;
    cur = '0;
    have_w0 = 1'b0;
    started = 1'b0;
    blocks.delete();
    misalign = 0;
    foreach (words[i]) begin
      if (words[i][34]) begin
        if (have_w0) misalign++;
        cur.hdr = words[i][33:32];
        cur.w0  = words[i][31:0];
        have_w0 = 1'b1;
        started = 1'b1;
      end else if (have_w0) begin
        if (words[i][33:32] !== cur.hdr) misalign++;
        cur.w1 = words[i][31:0];
        blocks.push_back(cur);
        have_w0 = 1'b0;
      end else if (started) begin
        misalign++;
      end
    end
  endtask

  task automatic start_capture();
    words.delete();
    exp_q.delete();
    und_cnt = 0;
    cap_en  = 1'b1;
  endtask

  task automatic finish_capture(input string tag, input int unsigned exp_und);
    int s;
    int unsigned nstart, idx;
    repeat (30) @(negedge i_clk);
    cap_en = 1'b0;
    build_blocks();
    s = -1;
    nstart = 0;
    foreach (blocks[i]) begin
      if (blocks[i] == B_START) begin
        if (s < 0) s = i;
        nstart++;
      end
    end
    check({tag, "_starts"},   66'(nstart),   66'(1));
    check({tag, "_align"},    66'(misalign), 66'(0));
    check({tag, "_underrun"}, 66'(und_cnt),  66'(exp_und));
    if (s >= 0) begin
      foreach (exp_q[j]) begin
        idx = 32'(s) + 1 + j;
        if (idx < blocks.size()) check($sformatf("%s_blk%0d", tag, j), blocks[idx], exp_q[j]);
        else check($sformatf("%s_blk%0d_missing", tag, j), 66'(blocks.size()), 66'(idx + 1));
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_data",   66'(o_data),             66'(0));
    check("rst_dv",     66'(o_data_valid),       66'(0));
    check("rst_hdr",    66'(o_header),           66'(2'b10));
    check("rst_hv",     66'(o_header_valid),     66'(0));
    check("rst_ready",  66'(o_eths_slave_ready), 66'(0));
    check("rst_underrun", 66'(o_underrun),       66'(0));

    // Idle stream straight out of reset
    i_rst_n = 1'b1;
    start_capture();
    repeat (12) @(negedge i_clk);
    cap_en = 1'b0;
    check("idle_count", 66'(words.size() >= 4), 66'(1));
    for (int i = 0; i < 4; i++) begin
      if (i < words.size())
        check($sformatf("idle_w%0d", i), 66'(words[i]),
              (i % 2 == 0) ? 66'({1'b1, 2'b10, 32'h78000000}) : 66'({1'b0, 2'b10, 32'h0}));
    end

    // 8-byte frame: DATA then TERM_0
    start_capture();
    exp_q.push_back({2'b01, 32'h00010203, 32'h04050607});
    exp_q.push_back({2'b10, 32'hE1000000, 32'h00000000});
    exp_q.push_back(B_IDLE);
    send_beat(32'h03020100, 2'd3, 1'b0, 1'b0);
    send_beat(32'h07060504, 2'd3, 1'b1, 1'b0);
    finish_capture("f8", 0);

    // 5-byte frame: TERM_5
    start_capture();
    exp_q.push_back({2'b10, 32'h4B000102, 32'h03040000});
    exp_q.push_back(B_IDLE);
    send_beat(32'h03020100, 2'd3, 1'b0, 1'b0);
    send_beat(32'h00000004, 2'd0, 1'b1, 1'b0);
    finish_capture("f5", 0);

    // 3-byte frame: TERM_3
    start_capture();
    exp_q.push_back({2'b10, 32'h2D000102, 32'h00000000});
    exp_q.push_back(B_IDLE);
    send_beat(32'h00020100, 2'd2, 1'b1, 1'b0);
    finish_capture("f3", 0);

    // 4-byte frame: TERM_4
    start_capture();
    exp_q.push_back({2'b10, 32'h33000102, 32'h03000000});
    exp_q.push_back(B_IDLE);
    send_beat(32'h03020100, 2'd3, 1'b1, 1'b0);
    finish_capture("f4", 0);

    // Underrun: valid drops for 3 cycles after the first beat
    start_capture();
    exp_q.push_back(B_ERROR);
    exp_q.push_back(B_IDLE);
    exp_q.push_back(B_IDLE);
    send_beat(32'h03020100, 2'd3, 1'b0, 1'b0);
    repeat (3) @(negedge i_clk);
    send_beat(32'h07060504, 2'd3, 1'b0, 1'b0);
    send_beat(32'h0B0A0908, 2'd3, 1'b1, 1'b0);
    finish_capture("urun", 1);

    // Abort on the last beat
    start_capture();
    exp_q.push_back(B_ERROR);
    exp_q.push_back(B_IDLE);
    send_beat(32'h03020100, 2'd3, 1'b0, 1'b0);
    send_beat(32'h07060504, 2'd3, 1'b1, 1'b1);
    finish_capture("abort", 0);

    // 16-byte frame with a gearbox slip between the halves of the first DATA block
    start_capture();
    exp_q.push_back({2'b01, 32'h00010203, 32'h04050607});
    exp_q.push_back({2'b01, 32'h08090A0B, 32'h0C0D0E0F});
    exp_q.push_back({2'b10, 32'hE1000000, 32'h00000000});
    exp_q.push_back(B_IDLE);
    fork
      begin
        send_beat(32'h03020100, 2'd3, 1'b0, 1'b0);
        send_beat(32'h07060504, 2'd3, 1'b0, 1'b0);
        send_beat(32'h0B0A0908, 2'd3, 1'b0, 1'b0);
        send_beat(32'h0F0E0D0C, 2'd3, 1'b1, 1'b0);
      end
      begin : slip
        logic [31:0] w;
        int unsigned n;
        logic seen;
        n = 0;
        seen = 1'b0;
        w = '0;
        while (!seen && n < 200) begin
          @(negedge i_clk);
          n++;
          if (o_header_valid && o_header == 2'b01) seen = 1'b1;
        end
        check("slip_seen", 66'(seen), 66'(1));
        if (seen) begin
          w = o_data;
          i_tx_ready = 1'b0;
          @(negedge i_clk);
          check("slip_dv",   66'(o_data_valid),   66'(0));
          check("slip_hv",   66'(o_header_valid), 66'(0));
          check("slip_hold", 66'(o_data),         66'(w));
          i_tx_ready = 1'b1;
        end
      end
    join
    finish_capture("slip", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
